vending_credit_ctrl: RTL and testbench
======================================

# vending_credit_ctrl

Parametrised vending controller: accumulates credit from nickel, dime, quarter and dollar inputs and dispenses when credit reaches `PRICE`. Residual credit or a cancelled sale is refunded as a coin-by-coin change sequence over a valid/ready handshake. It sits between the coin acceptor (single-cycle coin strobes) and the product/coin ejector mechanics. All money is counted in units of 5 cents.

## Interface
- `PRICE`, default 15: item price in 5-cent units. Legal range 1 .. 2^CREDIT_W-1.
- `CREDIT_W`, default 6: credit register width. Must be ≥ 5 so it can hold a dollar (20 units).
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `n_in` input, 1 bit: nickel strobe (1 unit).
- `d_in` input, 1 bit: dime strobe (2 units).
- `q_in` input, 1 bit: quarter strobe (5 units).
- `dl_in` input, 1 bit: dollar strobe (20 units).
- `cancel` input, 1 bit: refund request.
- `chg_ready` input, 1 bit: ejector can take a change coin this cycle.
- `dispense` output, 1 bit: one-cycle vend pulse.
- `chg_valid` output, 1 bit: a change coin is offered.
- `chg_coin` output, 2 bits: offered coin; 01 = nickel, 10 = dime, 11 = quarter, 00 when idle.
- `coin_reject` output, 1 bit: one-cycle pulse; the coin sampled at the previous edge was refused.
- `credit` output, CREDIT_W bits: current credit.

## Operation
- Coin inputs are sampled every rising edge. Each cycle a strobe is high counts as one coin.
- States: IDLE, VEND, CHANGE. Reset → IDLE.
- **IDLE, exactly one legal coin strobe high, no cancel:**
  - Compute sum = credit + value.
  - If sum > 2^CREDIT_W-1: reject the coin; credit is unchanged.
  - Else if sum ≥ PRICE: credit ← sum − PRICE; go to VEND.
  - Else: credit ← sum; stay in IDLE.
- **IDLE, more than one coin strobe high in the same cycle:** reject all of them (a single coin_reject pulse); credit is unchanged.
- **IDLE, cancel high:**
  - If credit > 0: go to CHANGE. Any coin in that cycle is rejected.
  - If credit = 0: cancel is ignored. A coin in that cycle is still rejected (cancel has priority).
- **VEND:** lasts exactly one cycle with `dispense` = 1. Next state is CHANGE if credit ≠ 0, else IDLE.
- **CHANGE:**
  - `chg_valid` = 1 and `chg_coin` = largest of quarter (5), dime (2), nickel (1) that is ≤ credit.
  - On an edge with `chg_ready` = 1: credit ← credit − coin value. When the new credit is 0, go to IDLE.
  - `chg_valid` stays high while `chg_ready` is low; `chg_coin` is stable while unaccepted.
- Coins presented in VEND or CHANGE are rejected. Cancel in VEND or CHANGE is ignored.
- Dollars are never returned as change.
- `dispense`, `chg_valid` and `chg_coin` are Moore outputs decoded from the state and credit registers.
- `coin_reject` is a registered pulse.

## Timing
- Reset values: state IDLE, credit 0, dispense 0, chg_valid 0, chg_coin 00, coin_reject 0.
- Reset mid-operation (any state) clears everything immediately. Untransferred change is forfeited.
- **Coin-to-dispense latency:** the edge that accepts the completing coin enters VEND, so `dispense` is high for the following cycle only.
- **Change handshake:** one coin transfers per edge with valid & ready. Back-to-back transfers are allowed while `chg_ready` is held high.
- **Refund latency:** `chg_valid` rises in the cycle after the edge that samples `cancel`.
- **`coin_reject` timing:** high in the cycle after the edge that sampled the refused coin.

## Configuration
- `VEND_DOLLAR_EN` defined: `dl_in` is accepted as 20 units per the rules above.
- `VEND_DOLLAR_EN` undefined: the `dl_in` port remains. Any `dl_in` strobe is rejected (coin_reject pulse, credit unchanged), but it still counts toward the multiple-coin rule.

## Test plan
- **Exact price, three quarters:** PRICE=15; q_in for 3 separate cycles → credit goes 5, 10, 0; dispense is one pulse after the 3rd edge; no chg_valid; back in IDLE.
- **Dollar with change (VEND_DOLLAR_EN):** PRICE=15; dl_in once → credit 5 and dispense pulse; then chg_valid with chg_coin=11. chg_ready=1 → credit 0, IDLE.
- **Refund mix with stalled ejector:** PRICE=15; d_in, n_in, d_in (credit 5); cancel → chg_coin=11. With chg_ready held low for 3 cycles, chg_valid/chg_coin stay steady. Then chg_ready=1 → credit 0, IDLE.
- **Greedy change split:** PRICE=1; q_in, then d_in while in VEND/CHANGE → d_in is rejected (coin_reject pulse). Change sequence from credit 4 is 10, 10.
- **Illegal or conflicting inputs:** q_in and n_in in the same cycle → one coin_reject pulse, credit unchanged. cancel with credit 0 → no change activity.
- **Overflow and mid-change reset:** PRICE=63, CREDIT_W=6; coins up to credit 60, then q_in → rejected (65 > 63). Then cancel and assert rst during CHANGE → all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/vending_credit_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : vending_credit_ctrl                                              |
// | Brief    : Coin credit accumulator with vend pulse and greedy change refund. |
// |            Define VEND_DOLLAR_EN to accept dl_in as 20 units.                |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module vending_credit_ctrl #(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                n_in,
  input  logic                d_in,
  input  logic                q_in,
  input  logic                dl_in,
  input  logic                cancel,
  input  logic                chg_ready,
  output logic                dispense,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  localparam logic [CREDIT_W:0] C_MAX   = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [CREDIT_W:0] C_PRICE = (CREDIT_W+1)'(PRICE);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                reject_q, reject_d;

  logic [2:0]          w_cnt;
  logic                w_any;
  logic                w_multi;
  logic                w_dl_blocked;
  logic [4:0]          w_val;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_chg_val;
  logic [CREDIT_W-1:0] w_chg_left;
  logic [1:0]          w_chg_code;

  assign w_cnt   = {2'b00, n_in} + {2'b00, d_in} + {2'b00, q_in} + {2'b00, dl_in};
  assign w_any   = (w_cnt != 3'd0);
  assign w_multi = (w_cnt > 3'd1);

`ifdef VEND_DOLLAR_EN
  assign w_dl_blocked = 1'b0;
`else
  assign w_dl_blocked = dl_in;
`endif

  assign w_val = n_in ? 5'd1 : d_in ? 5'd2 : q_in ? 5'd5 : 5'd20;
  assign w_sum = {1'b0, credit_q} + {{(CREDIT_W-4){1'b0}}, w_val};

  // Greedy refund: largest returnable coin not exceeding the remaining credit.
  always_comb begin
    if (credit_q >= CREDIT_W'(5)) begin
      w_chg_val  = CREDIT_W'(5);
      w_chg_code = 2'b11;
    end else if (credit_q >= CREDIT_W'(2)) begin
      w_chg_val  = CREDIT_W'(2);
      w_chg_code = 2'b10;
    end else begin
      w_chg_val  = CREDIT_W'(1);
      w_chg_code = 2'b01;
    end
  end

  assign w_chg_left = credit_q - w_chg_val;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cancel) begin
          reject_d = w_any;
          if (credit_q != '0) state_d = ST_CHANGE;
        end else if (w_multi || w_dl_blocked) begin
          reject_d = 1'b1;
        end else if (w_any) begin
          if (w_sum > C_MAX) begin
            reject_d = 1'b1;
          end else if (w_sum >= C_PRICE) begin
            credit_d = CREDIT_W'(w_sum - C_PRICE);
            state_d  = ST_VEND;
          end else begin
            credit_d = w_sum[CREDIT_W-1:0];
          end
        end
      end
      ST_VEND: begin
        reject_d = w_any;
        state_d  = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        reject_d = w_any;
        if (chg_ready) begin
          credit_d = w_chg_left;
          if (w_chg_left == '0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  assign dispense    = (state_q == ST_VEND);
  assign chg_valid   = (state_q == ST_CHANGE);
  assign chg_coin    = chg_valid ? w_chg_code : 2'b00;
  assign coin_reject = reject_q;
  assign credit      = credit_q;

endmodule
`default_nettype wire

// File: tb/tb_vending_credit_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_vending_credit_ctrl                                           |
// | Brief    : Directed vector bench for vending_credit_ctrl (PRICE 15, 1, 63). |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_vending_credit_ctrl;

  typedef struct {
    logic [5:0] in;   // {n, d, q, dl, cancel, chg_ready}
    logic [4:0] out;  // {dispense, chg_valid, chg_coin[1:0], coin_reject}
    logic [5:0] cr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic n_in = 1'b0, d_in = 1'b0, q_in = 1'b0, dl_in = 1'b0;
  logic cancel = 1'b0, chg_ready = 1'b0;

  logic       a_disp, a_val, a_rej;
  logic [1:0] a_coin;
  logic [5:0] a_cr;
  logic       b_disp, b_val, b_rej;
  logic [1:0] b_coin;
  logic [5:0] b_cr;
  logic       c_disp, c_val, c_rej;
  logic [1:0] c_coin;
  logic [5:0] c_cr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vending_credit_ctrl #(.PRICE(15), .CREDIT_W(6)) u_p15 (
    .clk(clk), .rst(rst), .n_in(n_in), .d_in(d_in), .q_in(q_in), .dl_in(dl_in),
    .cancel(cancel), .chg_ready(chg_ready), .dispense(a_disp), .chg_valid(a_val),
    .chg_coin(a_coin), .coin_reject(a_rej), .credit(a_cr)
  );

  vending_credit_ctrl #(.PRICE(1), .CREDIT_W(6)) u_p1 (
    .clk(clk), .rst(rst), .n_in(n_in), .d_in(d_in), .q_in(q_in), .dl_in(dl_in),
    .cancel(cancel), .chg_ready(chg_ready), .dispense(b_disp), .chg_valid(b_val),
    .chg_coin(b_coin), .coin_reject(b_rej), .credit(b_cr)
  );

  vending_credit_ctrl #(.PRICE(63), .CREDIT_W(6)) u_p63 (
    .clk(clk), .rst(rst), .n_in(n_in), .d_in(d_in), .q_in(q_in), .dl_in(dl_in),
    .cancel(cancel), .chg_ready(chg_ready), .dispense(c_disp), .chg_valid(c_val),
    .chg_coin(c_coin), .coin_reject(c_rej), .credit(c_cr)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_dut(input int sel, input string tag, input logic [4:0] eo,
                           input logic [5:0] ecr);
    logic [4:0] ao;
    logic [5:0] acr;
    case (sel)
      0:       begin ao = {a_disp, a_val, a_coin, a_rej}; acr = a_cr; end
      1:       begin ao = {b_disp, b_val, b_coin, b_rej}; acr = b_cr; end
      default: begin ao = {c_disp, c_val, c_coin, c_rej}; acr = c_cr; end
    endcase
    check({tag, ".dispense"},    32'(ao[4]),   32'(eo[4]));
    check({tag, ".chg_valid"},   32'(ao[3]),   32'(eo[3]));
    check({tag, ".chg_coin"},    32'(ao[2:1]), 32'(eo[2:1]));
    check({tag, ".coin_reject"}, 32'(ao[0]),   32'(eo[0]));
    check({tag, ".credit"},      32'(acr),     32'(ecr));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic step(input logic [5:0] in);
    {n_in, d_in, q_in, dl_in, cancel, chg_ready} = in;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    {n_in, d_in, q_in, dl_in, cancel, chg_ready} = 6'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic [5:0] in, input logic [4:0] out, input logic [5:0] cr);
    vec_t v;
    v.in  = in;
    v.out = out;
    v.cr  = cr;
    return v;
  endfunction

  vec_t tbl[23];

  initial begin
    tbl[0]  = mk(6'b001000, 5'b00000, 6'd5);
    tbl[1]  = mk(6'b000000, 5'b00000, 6'd5);
    tbl[2]  = mk(6'b001000, 5'b00000, 6'd10);
    tbl[3]  = mk(6'b001000, 5'b10000, 6'd0);   // exact price -> vend
    tbl[4]  = mk(6'b000000, 5'b00000, 6'd0);
    tbl[5]  = mk(6'b101000, 5'b00001, 6'd0);   // two coins at once
    tbl[6]  = mk(6'b000000, 5'b00000, 6'd0);
    tbl[7]  = mk(6'b000010, 5'b00000, 6'd0);   // cancel with no credit
    tbl[8]  = mk(6'b100010, 5'b00001, 6'd0);
    tbl[9]  = mk(6'b010000, 5'b00000, 6'd2);
    tbl[10] = mk(6'b100000, 5'b00000, 6'd3);
    tbl[11] = mk(6'b010000, 5'b00000, 6'd5);
    tbl[12] = mk(6'b000010, 5'b01110, 6'd5);   // refund starts, ejector stalled
    tbl[13] = mk(6'b000000, 5'b01110, 6'd5);
    tbl[14] = mk(6'b100000, 5'b01111, 6'd5);
    tbl[15] = mk(6'b000010, 5'b01110, 6'd5);
    tbl[16] = mk(6'b000001, 5'b00000, 6'd0);
    tbl[17] = mk(6'b001000, 5'b00000, 6'd5);
    tbl[18] = mk(6'b001000, 5'b00000, 6'd10);
    tbl[19] = mk(6'b010000, 5'b00000, 6'd12);
    tbl[20] = mk(6'b001000, 5'b10000, 6'd2);
    tbl[21] = mk(6'b010000, 5'b01101, 6'd2);   // coin during vend refused
    tbl[22] = mk(6'b000001, 5'b00000, 6'd0);

    rst = 1'b1;
    #2;
    check_dut(0, "rst_async_p15", 5'b00000, 6'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_dut(0, "rst_p15", 5'b00000, 6'd0);
    check_dut(1, "rst_p1",  5'b00000, 6'd0);
    check_dut(2, "rst_p63", 5'b00000, 6'd0);

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].in);
      check_dut(0, $sformatf("vec%0d", i), tbl[i].out, tbl[i].cr);
    end

    do_reset();
    step(6'b000100);
`ifdef VEND_DOLLAR_EN
    check_dut(0, "dollar_vend", 5'b10000, 6'd5);
    step(6'b000000);
    check_dut(0, "dollar_chg",  5'b01110, 6'd5);
    step(6'b000001);
    check_dut(0, "dollar_done", 5'b00000, 6'd0);
`else
    check_dut(0, "dollar_rej",  5'b00001, 6'd0);
    step(6'b000000);
    check_dut(0, "dollar_idle", 5'b00000, 6'd0);
`endif
    step(6'b100100);
    check_dut(0, "dollar_multi", 5'b00001, 6'd0);

    do_reset();
    step(6'b001000);
    check_dut(1, "greedy_vend", 5'b10000, 6'd4);
    step(6'b010000);
    check_dut(1, "greedy_c1",   5'b01101, 6'd4);
    step(6'b000001);
    check_dut(1, "greedy_c2",   5'b01100, 6'd2);
    step(6'b000001);
    check_dut(1, "greedy_done", 5'b00000, 6'd0);

    do_reset();
    for (int i = 0; i < 12; i++) step(6'b001000);
    check_dut(2, "ovf_60",  5'b00000, 6'd60);
    step(6'b001000);
    check_dut(2, "ovf_rej", 5'b00001, 6'd60);
    step(6'b010000);
    check_dut(2, "ovf_62",  5'b00000, 6'd62);
    step(6'b100000);
    check_dut(2, "ovf_63",  5'b10000, 6'd0);

    do_reset();
    for (int i = 0; i < 12; i++) step(6'b001000);
    step(6'b000010);
    check_dut(2, "midrst_chg", 5'b01110, 6'd60);
    {n_in, d_in, q_in, dl_in, cancel, chg_ready} = 6'b0;
    #2;
    rst = 1'b1;
    #1;
    check_dut(2, "midrst_async", 5'b00000, 6'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(6'b000000);
    check_dut(2, "midrst_idle", 5'b00000, 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
